// File: rtl/uart_rx_if.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx_if
//  Description : Serial line, frame configuration and received-byte outputs
//                of the UART receiver, bundled with master/slave views.
//  Revision    : 1.0 - initial release
// ============================================================================
interface uart_rx_if;
   logic       S_Data;        // serial line, idle high
   logic       Parity_EN;     // frame carries a parity bit
   logic       Parity_type;   // 0 = even, 1 = odd
   logic [4:0] Prescale;      // clock cycles per bit (even, 6..30)
   logic       Parity_error;  // frame-end pulse: parity mismatch
   logic       stop_error;    // frame-end pulse: stop bit sampled low
   logic       Data_valid;    // frame-end pulse: error-free frame
   logic [7:0] P_Data;        // last correctly received byte

   // Line driver / consumer side
   modport master (
      output S_Data, Parity_EN, Parity_type, Prescale,
      input  Parity_error, stop_error, Data_valid, P_Data
   );

   // Receiver side
   modport slave (
      input  S_Data, Parity_EN, Parity_type, Prescale,
      output Parity_error, stop_error, Data_valid, P_Data
   );
endinterface
`default_nettype wire

// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx
//  Description : Oversampling UART receiver. Start-bit detection with glitch
//                rejection, 3-sample majority vote per bit, 8 data bits
//                LSB-first, optional even/odd parity, stop-bit check and
//                registered one-cycle frame-end strobes.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_rx (
   input  logic     clk,
   input  logic     rst_n,
   uart_rx_if.slave rx
);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } state_t;

   state_t     state_q, state_d;
   logic [4:0] edge_cnt_q, edge_cnt_d;
   logic [2:0] bit_cnt_q, bit_cnt_d;
   logic [2:0] samp_q, samp_d;
   logic [7:0] shift_q, shift_d;
   logic       par_fail_q, par_fail_d;
   logic [7:0] p_data_q, p_data_d;
   logic       data_valid_q, data_valid_d;
   logic       parity_error_q, parity_error_d;
   logic       stop_error_q, stop_error_d;

   // Edge-count landmarks inside one bit period
   logic [4:0] half, last, samp_lo, samp_hi, bit_ready;
   logic       is_last, is_ready, in_window, bit_val;

   assign half      = rx.Prescale >> 1;
   assign last      = rx.Prescale - 5'd1;
   assign samp_lo   = half - 5'd1;
   assign samp_hi   = half + 5'd1;
   assign bit_ready = half + 5'd2;

   assign is_last   = (edge_cnt_q == last);
   assign is_ready  = (edge_cnt_q == bit_ready);
   assign in_window = (edge_cnt_q >= samp_lo) && (edge_cnt_q <= samp_hi);

   // 2-of-3 majority of the samples taken around mid-bit
   assign bit_val = (samp_q[0] & samp_q[1]) |
                    (samp_q[0] & samp_q[2]) |
                    (samp_q[1] & samp_q[2]);

   // Next-state, counters, sampling, deserialisation and frame-end outputs.
   // At the smallest prescale the bit-ready and bit-end counts coincide, so
   // the per-bit actions below are independent ifs rather than an else chain.
   always_comb begin
      state_d        = state_q;
      edge_cnt_d     = edge_cnt_q;
      bit_cnt_d      = bit_cnt_q;
      samp_d         = samp_q;
      shift_d        = shift_q;
      par_fail_d     = par_fail_q;
      p_data_d       = p_data_q;
      data_valid_d   = 1'b0;
      parity_error_d = 1'b0;
      stop_error_d   = 1'b0;

      if (state_q != IDLE) begin
         edge_cnt_d = is_last ? 5'd0 : edge_cnt_q + 5'd1;
         if (in_window) begin
            samp_d = {samp_q[1:0], rx.S_Data};
         end
      end

      case (state_q)
         IDLE: begin
            edge_cnt_d = 5'd0;
            bit_cnt_d  = 3'd0;
            // The detection edge itself is edge count 0 of the start bit
            if (!rx.S_Data) begin
               state_d    = START;
               par_fail_d = 1'b0;
            end
         end

         START: begin
            if (is_last) begin
               state_d = DATA;
            end
            // A start bit that votes high was a glitch; this overrides the
            // bit-end advance when both land on the same edge.
            if (is_ready && bit_val) begin
               state_d    = IDLE;
               edge_cnt_d = 5'd0;
            end
         end

         DATA: begin
            if (is_ready) begin
               shift_d = {bit_val, shift_q[7:1]};
            end
            if (is_last) begin
               bit_cnt_d = bit_cnt_q + 3'd1;
               if (bit_cnt_q == 3'd7) begin
                  state_d = rx.Parity_EN ? PARITY : STOP;
               end
            end
         end

         PARITY: begin
            if (is_ready) begin
               par_fail_d = bit_val ^ (^shift_q) ^ rx.Parity_type;
            end
            if (is_last) begin
               state_d = STOP;
            end
         end

         STOP: begin
            if (is_last) begin
               state_d        = IDLE;
               parity_error_d = par_fail_q;
               stop_error_d   = ~bit_val;
               data_valid_d   = ~par_fail_q & bit_val;
               if (~par_fail_q & bit_val) begin
                  p_data_d = shift_q;
               end
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and datapath registers; reset aborts any frame in progress
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q        <= IDLE;
         edge_cnt_q     <= 5'd0;
         bit_cnt_q      <= 3'd0;
         samp_q         <= 3'd0;
         shift_q        <= 8'h00;
         par_fail_q     <= 1'b0;
         p_data_q       <= 8'h00;
         data_valid_q   <= 1'b0;
         parity_error_q <= 1'b0;
         stop_error_q   <= 1'b0;
      end else begin
         state_q        <= state_d;
         edge_cnt_q     <= edge_cnt_d;
         bit_cnt_q      <= bit_cnt_d;
         samp_q         <= samp_d;
         shift_q        <= shift_d;
         par_fail_q     <= par_fail_d;
         p_data_q       <= p_data_d;
         data_valid_q   <= data_valid_d;
         parity_error_q <= parity_error_d;
         stop_error_q   <= stop_error_d;
      end
   end

   assign rx.P_Data       = p_data_q;
   assign rx.Data_valid   = data_valid_q;
   assign rx.Parity_error = parity_error_q;
   assign rx.stop_error   = stop_error_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_rx
//  Description : Self-checking bench for uart_rx: directed frame table,
//                multi-cycle corner sequences and randomized frames against
//                a frame-level reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   uart_rx_if rx_if ();

   uart_rx u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .rx    (rx_if)
   );

   always #5 clk = ~clk;

   int unsigned cyc = 0;
   always @(posedge clk) cyc++;

   // Every output strobe seen on a falling edge, with the cycle it belongs to
   typedef struct {
      int unsigned cycle;
      logic        dv;
      logic        pe;
      logic        se;
      logic [7:0]  data;
   } ev_t;
   ev_t evq[$];

   always @(negedge clk) begin
      if (rx_if.Data_valid !== 1'b0 || rx_if.Parity_error !== 1'b0 ||
          rx_if.stop_error !== 1'b0)
         evq.push_back('{cyc, rx_if.Data_valid, rx_if.Parity_error,
                         rx_if.stop_error, rx_if.P_Data});
   end

   int errors = 0;
   int checks = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Hold one bit on the line for one bit period (called on a falling edge)
   task automatic drive_bit(input logic b);
      rx_if.S_Data = b;
      repeat (int'(rx_if.Prescale)) @(negedge clk);
   endtask

   // Drive a whole frame; det is the rising edge that first sees the start bit
   task automatic send_frame(input logic [7:0] data, input logic par_bit,
                             input logic stop_bit, output int unsigned det);
      det = cyc + 1;
      drive_bit(1'b0);
      for (int i = 0; i < 8; i++) drive_bit(data[i]);
      if (rx_if.Parity_EN) drive_bit(par_bit);
      drive_bit(stop_bit);
      rx_if.S_Data = 1'b1;
   endtask

   // Pop the oldest strobe and compare it against the expected frame end
   task automatic check_ev(input string tag, input int unsigned exp_cyc,
                           input logic dv, input logic pe, input logic se,
                           input logic [7:0] pdata);
      ev_t e;
      chk({tag, " strobe_present"}, evq.size() > 0, 1'b1);
      if (evq.size() > 0) begin
         e = evq.pop_front();
         chk({tag, " cycle"},        e.cycle, exp_cyc);
         chk({tag, " Data_valid"},   e.dv, dv);
         chk({tag, " Parity_error"}, e.pe, pe);
         chk({tag, " stop_error"},   e.se, se);
         chk({tag, " P_Data"},       e.data, pdata);
      end
   endtask

   task automatic check_quiet(input string tag);
      chk({tag, " extra_strobes"}, evq.size(), 0);
      evq.delete();
   endtask

   function automatic int frame_bits(input logic pen);
      return pen ? 11 : 10;
   endfunction

   // Directed frames: line content plus hand-computed results
   typedef struct {
      string      name;
      logic [4:0] presc;
      logic       pen;
      logic       ptype;
      logic [7:0] data;
      logic       par_bit;
      logic       stop_bit;
      logic       dv;
      logic       pe;
      logic       se;
      logic [7:0] pdata;
   } vec_t;

   vec_t vecs[8];

   logic [7:0]  model_pdata;
   int unsigned det, det2;

   initial begin
      vecs[0] = '{"ab_even",      5'd8,  1'b1, 1'b0, 8'hAB, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'hAB};
      vecs[1] = '{"aa_par_err",   5'd8,  1'b1, 1'b0, 8'hAA, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'hAB};
      vecs[2] = '{"ff_stop_err",  5'd8,  1'b1, 1'b0, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'hAB};
      vecs[3] = '{"both_err",     5'd8,  1'b1, 1'b1, 8'h3C, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'hAB};
      vecs[4] = '{"aa_nopar",     5'd8,  1'b0, 1'b0, 8'hAA, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'hAA};
      vecs[5] = '{"p6_odd",       5'd6,  1'b1, 1'b1, 8'h5A, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h5A};
      vecs[6] = '{"p30_nopar",    5'd30, 1'b0, 1'b0, 8'hC3, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'hC3};
      vecs[7] = '{"p16_nopar_se", 5'd16, 1'b0, 1'b1, 8'h0F, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'hC3};

      rx_if.S_Data      = 1'b1;
      rx_if.Parity_EN   = 1'b0;
      rx_if.Parity_type = 1'b0;
      rx_if.Prescale    = 5'd8;

      // Reset state
      repeat (3) @(negedge clk);
      chk("reset P_Data",       rx_if.P_Data, 8'h00);
      chk("reset Data_valid",   rx_if.Data_valid, 1'b0);
      chk("reset Parity_error", rx_if.Parity_error, 1'b0);
      chk("reset stop_error",   rx_if.stop_error, 1'b0);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      evq.delete();

      // Directed frame table
      for (int i = 0; i < 8; i++) begin
         rx_if.Prescale    = vecs[i].presc;
         rx_if.Parity_EN   = vecs[i].pen;
         rx_if.Parity_type = vecs[i].ptype;
         repeat (2) @(negedge clk);
         send_frame(vecs[i].data, vecs[i].par_bit, vecs[i].stop_bit, det);
         repeat (3) @(negedge clk);
         check_ev(vecs[i].name, det + frame_bits(vecs[i].pen) * vecs[i].presc,
                  vecs[i].dv, vecs[i].pe, vecs[i].se, vecs[i].pdata);
         check_quiet(vecs[i].name);
      end

      // Back-to-back frames: the second start is only seen one cycle late,
      // because the receiver spends the first low cycle leaving STOP
      rx_if.Prescale    = 5'd8;
      rx_if.Parity_EN   = 1'b1;
      rx_if.Parity_type = 1'b0;
      repeat (2) @(negedge clk);
      send_frame(8'hAF, 1'b0, 1'b1, det);
      send_frame(8'h0B, 1'b1, 1'b1, det2);
      repeat (3) @(negedge clk);
      check_ev("b2b_first",  det + 88,      1'b1, 1'b0, 1'b0, 8'hAF);
      check_ev("b2b_second", det2 + 1 + 88, 1'b1, 1'b0, 1'b0, 8'h0B);
      check_quiet("b2b");

      // Short low glitches are rejected, then a clean odd-parity frame
      rx_if.Parity_type = 1'b1;
      rx_if.S_Data = 1'b0;
      @(negedge clk);
      rx_if.S_Data = 1'b1;
      repeat (12) @(negedge clk);
      rx_if.S_Data = 1'b0;
      repeat (2) @(negedge clk);
      rx_if.S_Data = 1'b1;
      repeat (12) @(negedge clk);
      check_quiet("glitch");
      send_frame(8'hFF, 1'b1, 1'b1, det);
      repeat (3) @(negedge clk);
      check_ev("after_glitch", det + 88, 1'b1, 1'b0, 1'b0, 8'hFF);
      check_quiet("after_glitch");

      // Reset during the data bits clears outputs at once, no strobe follows
      rx_if.Parity_EN = 1'b0;
      repeat (2) @(negedge clk);
      drive_bit(1'b0);
      drive_bit(1'b1);
      drive_bit(1'b0);
      drive_bit(1'b1);
      #2 rst_n = 1'b0;
      #1;
      chk("midreset P_Data",       rx_if.P_Data, 8'h00);
      chk("midreset Data_valid",   rx_if.Data_valid, 1'b0);
      chk("midreset Parity_error", rx_if.Parity_error, 1'b0);
      chk("midreset stop_error",   rx_if.stop_error, 1'b0);
      rx_if.S_Data = 1'b1;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (100) @(negedge clk);
      check_quiet("midreset");
      send_frame(8'h96, 1'b0, 1'b1, det);
      repeat (3) @(negedge clk);
      check_ev("post_reset", det + 80, 1'b1, 1'b0, 1'b0, 8'h96);
      check_quiet("post_reset");

      // Randomized frames against the frame-level model
      model_pdata = 8'h96;
      for (int n = 0; n < 40; n++) begin
         logic [4:0] p;
         logic       pen, ptype, flip, stop_b, par_b, pe, se, dv;
         logic [7:0] d;
         p      = 5'(6 + 2 * $urandom_range(0, 12));
         pen    = 1'($urandom_range(0, 1));
         ptype  = 1'($urandom_range(0, 1));
         d      = 8'($urandom);
         flip   = ($urandom_range(0, 3) == 0);
         stop_b = ($urandom_range(0, 4) != 0);
         par_b  = (^d) ^ ptype ^ flip;
         pe     = pen & flip;
         se     = ~stop_b;
         dv     = ~pe & ~se;
         if (dv) model_pdata = d;
         rx_if.Prescale    = p;
         rx_if.Parity_EN   = pen;
         rx_if.Parity_type = ptype;
         @(negedge clk);
         send_frame(d, par_b, stop_b, det);
         repeat ($urandom_range(2, 5)) @(negedge clk);
         check_ev($sformatf("rand%0d", n), det + frame_bits(pen) * p, dv, pe, se, model_pdata);
         check_quiet($sformatf("rand%0d", n));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
